// File: rtl/ai_core_pkg.sv
// Shared types for the AI core datapath: lane resize modes,
// clamp bounds and the skid buffer occupancy states.
package ai_core_pkg;

  typedef enum logic [1:0] {
    RESIZE_EXT,
    RESIZE_PASS,
    RESIZE_SAT,
    RESIZE_TRUNC
  } resize_e;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_TWO
  } buf_state_e;

  typedef struct packed {
    logic [63:0] smin;
    logic [63:0] smax;
    logic [63:0] umax;
  } bounds_t;

  function automatic resize_e resize_mode(
    input int   in_w,
    input int   out_w,
    input logic sat_en
  );
    resize_e m;
    if (out_w > in_w) m = RESIZE_EXT;
    else if (out_w == in_w) m = RESIZE_PASS;
    else if (sat_en) m = RESIZE_SAT;
    else m = RESIZE_TRUNC;
    return m;
  endfunction

  // Bounds are 64-bit two's complement; umax is non-negative
  function automatic bounds_t clamp_bounds(input int w);
    bounds_t b;
    b.umax = (64'sd1 <<< w) - 64'sd1;
    b.smax = (64'sd1 <<< (w - 1)) - 64'sd1;
    b.smin = -(64'sd1 <<< (w - 1));
    return b;
  endfunction

endpackage

// File: rtl/extender_stream_n_skid_buffer.sv
// Two-entry valid/ready buffer; ready is a flop that
// reflects "skid entry empty" so no input-to-ready path exists.
module skid_buffer
  import ai_core_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q, ready_d;
  logic             in_fire, out_fire;

  assign in_fire     = in_valid_i & ready_q;
  assign out_fire    = (state_q != BUF_EMPTY) & out_ready_i;
  assign in_ready_o  = ready_q;
  assign out_valid_o = (state_q != BUF_EMPTY);
  assign out_data_o  = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data_i;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (in_fire && !out_fire) begin
          skid_d  = in_data_i;
          state_d = BUF_TWO;
        end else if (in_fire) begin
          main_d = in_data_i;
        end else if (out_fire) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    ready_d = (state_d != BUF_TWO);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/extender_stream_n.sv
// Multi-lane stream width converter: extend, pass, saturate or
// truncate each lane, buffered by a skid buffer, with a clamp counter.
module extender_stream_n
  import ai_core_pkg::*;
#(
  parameter int IN_NUM   = 4,
  parameter int IN_SIZE  = 8,
  parameter int OUT_SIZE = 12,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [IN_SIZE-1:0]  in_data_i [0:IN_NUM-1],
  input  logic                signed_i,
  input  logic                sat_en_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [OUT_SIZE-1:0] out_data_o [0:IN_NUM-1],
  output logic [IN_NUM-1:0]   out_sat_o,
  output logic [CNT_W-1:0]    sat_cnt_o,
  input  logic                sat_clr_i
);

  localparam int      LW  = OUT_SIZE + 1;
  localparam int      BW  = IN_NUM * LW;
  localparam bounds_t BND = clamp_bounds(OUT_SIZE);

  resize_e            mode;
  logic [BW-1:0]      conv, held;
  logic signed [63:0] v, hi, lo;
  logic [63:0]        r;
  logic               s;
  logic               out_fire;
  logic [CNT_W-1:0]   sat_cnt_d, sat_cnt_q;

  // Each lane is lifted to 64 bits, clamped there, then cut down
  always_comb begin
    mode = resize_mode(IN_SIZE, OUT_SIZE, sat_en_i);
    conv = '0;
    hi   = signed_i ? $signed(BND.smax) : $signed(BND.umax);
    lo   = signed_i ? $signed(BND.smin) : 64'sd0;
    v    = '0;
    r    = '0;
    s    = 1'b0;
    for (int l = 0; l < IN_NUM; l++) begin
      v = {{(64-IN_SIZE){signed_i & in_data_i[l][IN_SIZE-1]}},
           in_data_i[l]};
      r = v;
      s = 1'b0;
      if (mode == RESIZE_SAT) begin
        if (v > hi) begin
          r = hi;
          s = 1'b1;
        end else if (v < lo) begin
          r = lo;
          s = 1'b1;
        end
      end
      conv[l*LW +: LW] = {s, r[OUT_SIZE-1:0]};
    end
  end

  skid_buffer #(
    .WIDTH(BW)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (conv),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (held)
  );

  always_comb begin
    for (int l = 0; l < IN_NUM; l++) begin
      out_data_o[l] = held[l*LW +: OUT_SIZE];
      out_sat_o[l]  = held[l*LW + OUT_SIZE];
    end
  end

  assign out_fire  = out_valid_o & out_ready_i;
  assign sat_cnt_o = sat_cnt_q;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr_i) begin
      sat_cnt_d = '0;
    end else if (out_fire && (|out_sat_o) && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) sat_cnt_q <= '0;
    else sat_cnt_q <= sat_cnt_d;
  end

endmodule

// File: tb/tb_extender_stream_n.sv
// Bench for extender_stream_n: a widening 8->12 instance and a
// narrowing 8->4 instance with a 2-bit counter, checked against a model.
module tb_extender_stream_n;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0][11:0] d;
    logic [N-1:0]       s;
  } ea_t;

  typedef struct packed {
    logic [N-1:0][3:0] d;
    logic [N-1:0]      s;
  } eb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_iv, a_ir, a_sg, a_se, a_ov, a_or, a_clr;
  logic [7:0]  a_in  [0:N-1];
  logic [11:0] a_out [0:N-1];
  logic [N-1:0] a_sat;
  logic [15:0] a_cnt;

  logic        b_iv, b_ir, b_sg, b_se, b_ov, b_or, b_clr;
  logic [7:0]  b_in  [0:N-1];
  logic [3:0]  b_out [0:N-1];
  logic [N-1:0] b_sat;
  logic [1:0]  b_cnt;

  logic [7:0] na_d [0:N-1];
  logic [7:0] nb_d [0:N-1];
  bit na_sg, na_se, nb_sg, nb_se;
  bit a_took, b_took;
  int unsigned cnt_a, cnt_b;
  int b_acc;
  ea_t qa[$];
  eb_t qb[$];
  int n_cmp = 0;
  int n_bad = 0;

  extender_stream_n #(
    .IN_NUM(N), .IN_SIZE(8), .OUT_SIZE(12), .CNT_W(16)
  ) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_in),
    .signed_i(a_sg), .sat_en_i(a_se),
    .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_out),
    .out_sat_o(a_sat), .sat_cnt_o(a_cnt), .sat_clr_i(a_clr)
  );

  extender_stream_n #(
    .IN_NUM(N), .IN_SIZE(8), .OUT_SIZE(4), .CNT_W(2)
  ) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_in),
    .signed_i(b_sg), .sat_en_i(b_se),
    .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_out),
    .out_sat_o(b_sat), .sat_cnt_o(b_cnt), .sat_clr_i(b_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value semantics: interpret, clamp to the target range, wrap
  function automatic logic [63:0] ref_lane(input logic [7:0] x,
      input bit sg, input bit se, input int ow, output bit sat);
    longint v, lo, hi, r;
    v = sg ? longint'($signed(x)) : longint'(x);
    r = v;
    sat = 1'b0;
    if (ow < 8 && se) begin
      lo = sg ? -(longint'(1) << (ow - 1)) : 0;
      hi = sg ? (longint'(1) << (ow - 1)) - 1
              : (longint'(1) << ow) - 1;
      if (v > hi) begin r = hi; sat = 1'b1; end
      else if (v < lo) begin r = lo; sat = 1'b1; end
    end
    return 64'(r & ((longint'(1) << ow) - 1));
  endfunction

  task automatic a_step(input bit offer, input bit ordy, input bit clr);
    ea_t e;
    logic [63:0] r;
    bit s, fire;
    if (!a_iv || a_took) begin
      a_iv = offer;
      if (offer) begin a_in = na_d; a_sg = na_sg; a_se = na_se; end
    end
    a_or = ordy;
    a_clr = clr;
    chk("a_valid", 64'(a_ov), 64'(qa.size() > 0));
    chk("a_ready", 64'(a_ir), 64'(qa.size() < 2));
    chk("a_cnt", 64'(a_cnt), 64'(cnt_a));
    if (qa.size() > 0) begin
      for (int l = 0; l < N; l++)
        chk($sformatf("a_data%0d", l), 64'(a_out[l]), 64'(qa[0].d[l]));
      chk("a_sat", 64'(a_sat), 64'(qa[0].s));
    end
    fire = a_ov && ordy;
    a_took = a_iv && a_ir;
    if (clr) cnt_a = 0;
    else if (fire && qa.size() > 0 && qa[0].s != 0 && cnt_a < 65535)
      cnt_a++;
    if (fire && qa.size() > 0) void'(qa.pop_front());
    if (a_took) begin
      e = '0;
      for (int l = 0; l < N; l++) begin
        r = ref_lane(a_in[l], a_sg, a_se, 12, s);
        e.d[l] = r[11:0];
        e.s[l] = s;
      end
      qa.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic b_step(input bit offer, input bit ordy, input bit clr);
    eb_t e;
    logic [63:0] r;
    bit s, fire;
    if (!b_iv || b_took) begin
      b_iv = offer;
      if (offer) begin b_in = nb_d; b_sg = nb_sg; b_se = nb_se; end
    end
    b_or = ordy;
    b_clr = clr;
    chk("b_valid", 64'(b_ov), 64'(qb.size() > 0));
    chk("b_ready", 64'(b_ir), 64'(qb.size() < 2));
    chk("b_cnt", 64'(b_cnt), 64'(cnt_b));
    if (qb.size() > 0) begin
      for (int l = 0; l < N; l++)
        chk($sformatf("b_data%0d", l), 64'(b_out[l]), 64'(qb[0].d[l]));
      chk("b_sat", 64'(b_sat), 64'(qb[0].s));
    end
    fire = b_ov && ordy;
    b_took = b_iv && b_ir;
    if (clr) cnt_b = 0;
    else if (fire && qb.size() > 0 && qb[0].s != 0 && cnt_b < 3)
      cnt_b++;
    if (fire && qb.size() > 0) void'(qb.pop_front());
    if (b_took) begin
      e = '0;
      for (int l = 0; l < N; l++) begin
        r = ref_lane(b_in[l], b_sg, b_se, 4, s);
        e.d[l] = r[3:0];
        e.s[l] = s;
      end
      qb.push_back(e);
      b_acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_iv = 1'b0; a_or = 1'b0; a_clr = 1'b0;
    b_iv = 1'b0; b_or = 1'b0; b_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_a_valid", 64'(a_ov), 64'd0);
    chk("rst_a_ready", 64'(a_ir), 64'd1);
    chk("rst_a_sat", 64'(a_sat), 64'd0);
    chk("rst_a_cnt", 64'(a_cnt), 64'd0);
    chk("rst_b_valid", 64'(b_ov), 64'd0);
    chk("rst_b_ready", 64'(b_ir), 64'd1);
    chk("rst_b_sat", 64'(b_sat), 64'd0);
    chk("rst_b_cnt", 64'(b_cnt), 64'd0);
    for (int l = 0; l < N; l++) begin
      chk($sformatf("rst_a_data%0d", l), 64'(a_out[l]), 64'd0);
      chk($sformatf("rst_b_data%0d", l), 64'(b_out[l]), 64'd0);
    end
    rst_n = 1'b1;
    qa.delete(); qb.delete();
    cnt_a = 0; cnt_b = 0;
    a_took = 1'b0; b_took = 1'b0;
  endtask

  initial begin
    a_sg = 1'b0; a_se = 1'b0; b_sg = 1'b0; b_se = 1'b0;
    for (int l = 0; l < N; l++) begin
      a_in[l] = '0; b_in[l] = '0; na_d[l] = '0; nb_d[l] = '0;
    end
    @(negedge clk);
    do_reset();

    // widening, signed then unsigned
    na_d = '{8'h80, 8'h7F, 8'hFF, 8'h00};
    na_sg = 1'b1; na_se = 1'b1;
    a_step(1, 1, 0);
    chk("wide_s0", 64'(a_out[0]), 64'h F80);
    chk("wide_s1", 64'(a_out[1]), 64'h 07F);
    chk("wide_s2", 64'(a_out[2]), 64'h FFF);
    chk("wide_s3", 64'(a_out[3]), 64'h 000);
    chk("wide_s_sat", 64'(a_sat), 64'd0);
    na_sg = 1'b0;
    a_step(1, 1, 0);
    chk("wide_u0", 64'(a_out[0]), 64'h 080);
    chk("wide_u2", 64'(a_out[2]), 64'h 0FF);
    for (int i = 0; i < 60; i++) begin
      for (int l = 0; l < N; l++) na_d[l] = 8'($urandom);
      na_sg = 1'($urandom); na_se = 1'($urandom);
      a_step(($urandom % 4) != 0, ($urandom % 3) != 0, 0);
    end
    a_step(0, 0, 0);

    // narrowing: signed saturate, unsigned saturate, truncate
    nb_d = '{8'h7F, 8'h80, 8'h05, 8'hF9};
    nb_sg = 1'b1; nb_se = 1'b1;
    b_step(1, 1, 0);
    chk("nar_s0", 64'(b_out[0]), 64'h7);
    chk("nar_s1", 64'(b_out[1]), 64'h8);
    chk("nar_s2", 64'(b_out[2]), 64'h5);
    chk("nar_s3", 64'(b_out[3]), 64'h9);
    chk("nar_s_sat", 64'(b_sat), 64'b0011);
    nb_d = '{8'h10, 8'h0F, 8'h03, 8'hFF};
    nb_sg = 1'b0; nb_se = 1'b1;
    b_step(1, 1, 0);
    chk("nar_cnt1", 64'(b_cnt), 64'd1);
    chk("nar_u0", 64'(b_out[0]), 64'hF);
    chk("nar_u1", 64'(b_out[1]), 64'hF);
    chk("nar_u_sat", 64'(b_sat), 64'b1001);
    nb_se = 1'b0;
    b_step(1, 1, 0);
    chk("nar_cnt2", 64'(b_cnt), 64'd2);
    chk("trunc0", 64'(b_out[0]), 64'h0);
    chk("trunc1", 64'(b_out[1]), 64'hF);
    chk("trunc_sat", 64'(b_sat), 64'd0);
    b_step(0, 1, 0);
    chk("trunc_cnt_hold", 64'(b_cnt), 64'd2);

    // counter saturation and clear priority
    b_step(0, 1, 1);
    nb_d = '{8'h7F, 8'h80, 8'h05, 8'hF9};
    nb_sg = 1'b1; nb_se = 1'b1;
    for (int i = 0; i < 5; i++) b_step(1, 1, 0);
    b_step(0, 1, 0);
    chk("cnt_top", 64'(b_cnt), 64'd3);
    b_step(1, 1, 0);
    b_step(0, 1, 1);
    chk("cnt_clr_prio", 64'(b_cnt), 64'd0);

    // backpressure: 5 beats, ready low for 3 cycles
    b_acc = 0;
    nb_d[0] = 8'h01;
    b_step(1, 0, 0);
    nb_d[0] = 8'h02;
    b_step(1, 0, 0);
    chk("bp_ready_low", 64'(b_ir), 64'd0);
    nb_d[0] = 8'h03;
    b_step(1, 0, 0);
    for (int g = 0; g < 20 && b_acc < 5; g++) begin
      nb_d[0] = 8'(8'h04 + g);
      b_step(1, 1, 0);
    end
    chk("bp_accepted", 64'(b_acc), 64'd5);
    b_step(0, 1, 0);
    b_step(0, 1, 0);
    chk("bp_drained", 64'(b_ov), 64'd0);

    for (int i = 0; i < 300; i++) begin
      for (int l = 0; l < N; l++) nb_d[l] = 8'($urandom);
      nb_sg = 1'($urandom); nb_se = 1'($urandom);
      b_step(($urandom % 4) != 0, ($urandom % 3) != 0,
             ($urandom % 16) == 0);
    end

    // reset with both entries full
    b_step(0, 0, 0);
    b_step(0, 1, 0);
    b_step(0, 1, 0);
    b_step(1, 0, 0);
    b_step(1, 0, 0);
    chk("pre_rst_full", 64'(b_ir), 64'd0);
    do_reset();
    b_step(0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
